// File: rtl/register_file_param.sv
// register_file_param: parametrised 2-read / 1-write register file.
//   - combinational reads with write-first bypass on both read ports
//   - sequential bulk-clear engine (one entry per cycle) with busy flag
//   - writes arriving while the clear runs are dropped and flagged on wr_rej
//   - out-of-range writes are ignored, out-of-range reads return 0
// Optional feature macro: REGFILE_PARITY_EN (per-entry even parity with
// fault injection on write and combinational parity-error outputs).
module register_file_param #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] d_in,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] d_out_a,
    output logic [DATA_W-1:0] d_out_b,
    input  logic              clr,
`ifdef REGFILE_PARITY_EN
    input  logic              par_inj,
    output logic              par_err_a,
    output logic              par_err_b,
`endif
    output logic              busy,
    output logic              wr_rej
);

    // Write handshake: a write is taken on any edge where wr_en=1 while busy=0
    // and wr_addr<DEPTH. While busy=1 a write is dropped and wr_rej pulses high
    // for one cycle after that edge; out-of-range writes vanish without a pulse.

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              busy_q, busy_d;
    logic              wr_rej_q, wr_rej_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
`ifdef REGFILE_PARITY_EN
    logic [DEPTH-1:0]  par_q, par_d;
    logic              rd_par_a, rd_par_b;
`endif

    logic              wr_in_range;
    logic              wr_ok;
    logic              byp_a, byp_b;
    logic              hit_a, hit_b;
    logic [DATA_W-1:0] rd_data_a, rd_data_b;

    // Write acceptance and per-port bypass selection.
    always_comb begin
        wr_in_range = ({1'b0, wr_addr} < DEPTH_C);
        wr_ok       = wr_en && !reset && (state_q == ST_IDLE) && wr_in_range;
        byp_a       = wr_ok && (rd_addr_a == wr_addr);
        byp_b       = wr_ok && (rd_addr_b == wr_addr);
    end

    // Array read muxes; an address beyond DEPTH matches no entry and reads 0.
    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        hit_a     = 1'b0;
        hit_b     = 1'b0;
`ifdef REGFILE_PARITY_EN
        rd_par_a  = 1'b0;
        rd_par_b  = 1'b0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr_a == ADDR_W'(i)) begin
                rd_data_a = mem_q[i];
                hit_a     = 1'b1;
`ifdef REGFILE_PARITY_EN
                rd_par_a  = par_q[i];
`endif
            end
            if (rd_addr_b == ADDR_W'(i)) begin
                rd_data_b = mem_q[i];
                hit_b     = 1'b1;
`ifdef REGFILE_PARITY_EN
                rd_par_b  = par_q[i];
`endif
            end
        end
    end

    // Output data: write-first bypass overrides the stored value.
    always_comb begin
        d_out_a = byp_a ? d_in : rd_data_a;
        d_out_b = byp_b ? d_in : rd_data_b;
`ifdef REGFILE_PARITY_EN
        par_err_a = hit_a && !byp_a && ((^rd_data_a) != rd_par_a);
        par_err_b = hit_b && !byp_b && ((^rd_data_b) != rd_par_b);
`endif
    end

    // Next-state logic: writes only in IDLE, clearing only in CLEAR, so the
    // two can never touch the same entry in one cycle.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        wr_rej_d = 1'b0;
        mem_d    = mem_q;
`ifdef REGFILE_PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (wr_ok && (wr_addr == ADDR_W'(i))) begin
                        mem_d[i] = d_in;
`ifdef REGFILE_PARITY_EN
                        par_d[i] = (^d_in) ^ par_inj;
`endif
                    end
                end
                // The clr cycle itself is IDLE, so its write (above) still lands.
                if (clr) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            ST_CLEAR: begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (ptr_q == ADDR_W'(i)) begin
                        mem_d[i] = '0;
`ifdef REGFILE_PARITY_EN
                        par_d[i] = 1'b0;
`endif
                    end
                end
                // clr is ignored here: it neither restarts nor extends a clear.
                wr_rej_d = wr_en;
                if (ptr_q == LAST_PTR) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d   = ptr_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = '0;
            end
        endcase
        // busy mirrors the state being entered, so it is high for exactly
        // the DEPTH cycles spent in CLEAR.
        busy_d = (state_d == ST_CLEAR);
    end

    // State, pointer, flags and array registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            busy_q   <= 1'b0;
            wr_rej_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
`ifdef REGFILE_PARITY_EN
            par_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            busy_q   <= busy_d;
            wr_rej_q <= wr_rej_d;
            mem_q    <= mem_d;
`ifdef REGFILE_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign wr_rej = wr_rej_q;

endmodule

// File: tb/tb_register_file_param.sv
// tb_register_file_param: drives a DEPTH=8 and a DEPTH=6 instance with the
// same stimulus and compares both against an array-based reference model.
module tb_register_file_param;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] d_in;
    logic [2:0] rd_addr_a;
    logic [2:0] rd_addr_b;
    logic       clr;
    logic       par_inj;

    logic [7:0] o_a [2];
    logic [7:0] o_b [2];
    logic       o_busy [2];
    logic       o_rej [2];
    logic       o_pa [2];
    logic       o_pb [2];

    int n_checks;
    int n_errors;

    // reference model: contents, remaining clear cycles, reject flag, parity
    logic [7:0] m_mem [2][8];
    logic       m_par [2][8];
    int         m_busy [2];
    logic       m_rej [2];
    int         m_depth [2];

    register_file_param #(.DATA_W(8), .DEPTH(8)) dut8 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .d_in(d_in),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .d_out_a(o_a[0]), .d_out_b(o_b[0]), .clr(clr),
`ifdef REGFILE_PARITY_EN
        .par_inj(par_inj), .par_err_a(o_pa[0]), .par_err_b(o_pb[0]),
`endif
        .busy(o_busy[0]), .wr_rej(o_rej[0])
    );

    register_file_param #(.DATA_W(8), .DEPTH(6)) dut6 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .d_in(d_in),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .d_out_a(o_a[1]), .d_out_b(o_b[1]), .clr(clr),
`ifdef REGFILE_PARITY_EN
        .par_inj(par_inj), .par_err_a(o_pa[1]), .par_err_b(o_pb[1]),
`endif
        .busy(o_busy[1]), .wr_rej(o_rej[1])
    );

`ifndef REGFILE_PARITY_EN
    assign o_pa[0] = 1'b0;
    assign o_pa[1] = 1'b0;
    assign o_pb[0] = 1'b0;
    assign o_pb[1] = 1'b0;
`endif

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic m_wr_ok(int i);
        return wr_en && !reset && (m_busy[i] == 0) && (int'(wr_addr) < m_depth[i]);
    endfunction

    function automatic logic [7:0] m_read(int i, logic [2:0] ra);
        if (int'(ra) >= m_depth[i]) return 8'h00;
        if (m_wr_ok(i) && ra == wr_addr) return d_in;
        return m_mem[i][ra];
    endfunction

    function automatic logic m_perr(int i, logic [2:0] ra);
        if (int'(ra) >= m_depth[i]) return 1'b0;
        if (m_wr_ok(i) && ra == wr_addr) return 1'b0;
        return (^m_mem[i][ra]) != m_par[i][ra];
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                for (int k = 0; k < 8; k++) begin
                    m_mem[i][k] = 8'h00;
                    m_par[i][k] = 1'b0;
                end
                m_busy[i] = 0;
                m_rej[i]  = 1'b0;
            end else begin
                m_rej[i] = wr_en && (m_busy[i] > 0);
                if (m_busy[i] > 0) begin
                    m_mem[i][m_depth[i] - m_busy[i]] = 8'h00;
                    m_par[i][m_depth[i] - m_busy[i]] = 1'b0;
                    m_busy[i] = m_busy[i] - 1;
                end else begin
                    if (m_wr_ok(i)) begin
                        m_mem[i][wr_addr] = d_in;
                        m_par[i][wr_addr] = (^d_in) ^ par_inj;
                    end
                    if (clr) m_busy[i] = m_depth[i];
                end
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic en, input logic [2:0] wa, input logic [7:0] d,
                         input logic [2:0] ra, input logic [2:0] rb,
                         input logic c, input logic rst);
        wr_en     = en;
        wr_addr   = wa;
        d_in      = d;
        rd_addr_a = ra;
        rd_addr_b = rb;
        clr       = c;
        reset     = rst;
        par_inj   = 1'b0;
    endtask

    // Checks combinational outputs, advances one clock, checks registered outputs.
    task automatic cycle();
        #1;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (o_a[i] !== m_read(i, rd_addr_a)) begin
                n_errors++;
                $display("FAIL rd_a dut%0d addr=%0d: got %h expected %h", i, rd_addr_a, o_a[i], m_read(i, rd_addr_a));
            end
            n_checks++;
            if (o_b[i] !== m_read(i, rd_addr_b)) begin
                n_errors++;
                $display("FAIL rd_b dut%0d addr=%0d: got %h expected %h", i, rd_addr_b, o_b[i], m_read(i, rd_addr_b));
            end
`ifdef REGFILE_PARITY_EN
            n_checks++;
            if (o_pa[i] !== m_perr(i, rd_addr_a)) begin
                n_errors++;
                $display("FAIL par_err_a dut%0d addr=%0d: got %b expected %b", i, rd_addr_a, o_pa[i], m_perr(i, rd_addr_a));
            end
            n_checks++;
            if (o_pb[i] !== m_perr(i, rd_addr_b)) begin
                n_errors++;
                $display("FAIL par_err_b dut%0d addr=%0d: got %b expected %b", i, rd_addr_b, o_pb[i], m_perr(i, rd_addr_b));
            end
`endif
        end
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (o_busy[i] !== (m_busy[i] > 0)) begin
                n_errors++;
                $display("FAIL busy dut%0d: got %b expected %b", i, o_busy[i], (m_busy[i] > 0));
            end
            n_checks++;
            if (o_rej[i] !== m_rej[i]) begin
                n_errors++;
                $display("FAIL wr_rej dut%0d: got %b expected %b", i, o_rej[i], m_rej[i]);
            end
        end
    endtask

    task automatic fill(input logic [7:0] base);
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 3'(k), base + 8'(k), 3'(k), 3'(7 - k), 1'b0, 1'b0);
            cycle();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b1);
        @(posedge clk);
        model_edge();
        #1;
        cycle();
        drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd7, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (o_busy[0] !== 1'b0 || o_rej[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_flags: got busy=%b wr_rej=%b expected 0 0", o_busy[0], o_rej[0]);
        end
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 3'd0, 8'h00, 3'(k), 3'(7 - k), 1'b0, 1'b0);
            #1;
            n_checks++;
            if (o_a[0] !== 8'h00 || o_a[1] !== 8'h00) begin
                n_errors++;
                $display("FAIL reset_zero addr=%0d: got %h/%h expected 00", k, o_a[0], o_a[1]);
            end
            cycle();
        end
    endtask

    task automatic test_write_read();
        drive(1'b1, 3'd3, 8'hA5, 3'd0, 3'd1, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 3'd7, 8'h3C, 3'd0, 3'd1, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 3'd0, 8'h00, 3'd3, 3'd7, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (o_a[0] !== 8'hA5 || o_b[0] !== 8'h3C) begin
            n_errors++;
            $display("FAIL write_read: got a=%h b=%h expected a=a5 b=3c", o_a[0], o_b[0]);
        end
        n_checks++;
        if (o_a[1] !== 8'hA5 || o_b[1] !== 8'h00) begin
            n_errors++;
            $display("FAIL write_read_d6: got a=%h b=%h expected a=a5 b=00", o_a[1], o_b[1]);
        end
        cycle();
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 3'd0, 8'h00, 3'(k), 3'(k), 1'b0, 1'b0);
            cycle();
        end
    endtask

    task automatic test_bypass();
        drive(1'b1, 3'd5, 8'h77, 3'd5, 3'd5, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (o_a[0] !== 8'h77 || o_b[0] !== 8'h77) begin
            n_errors++;
            $display("FAIL bypass: got a=%h b=%h expected 77 77", o_a[0], o_b[0]);
        end
        cycle();
        drive(1'b0, 3'd0, 8'h00, 3'd5, 3'd4, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (o_a[0] !== 8'h77) begin
            n_errors++;
            $display("FAIL bypass_stored: got %h expected 77", o_a[0]);
        end
        cycle();
    endtask

    task automatic test_clear();
        int cnt8, cnt6;
        logic [7:0] exp6;
        cnt8 = 0;
        cnt6 = 0;
        fill(8'h10);
        drive(1'b0, 3'd0, 8'h00, 3'd6, 3'd0, 1'b1, 1'b0);
        cycle();
        for (int j = 1; j <= 12; j++) begin
            drive(1'b0, 3'd0, 8'h00, 3'd6, 3'(j % 8), 1'b0, 1'b0);
            #1;
            if (o_busy[1]) cnt6++;
            if (o_busy[0]) begin
                cnt8++;
                exp6 = (cnt8 <= 7) ? 8'h16 : 8'h00;
                n_checks++;
                if (o_a[0] !== exp6) begin
                    n_errors++;
                    $display("FAIL mid_clear busy_cycle=%0d: got %h expected %h", cnt8, o_a[0], exp6);
                end
            end
            cycle();
        end
        n_checks++;
        if (cnt8 != 8 || cnt6 != 6) begin
            n_errors++;
            $display("FAIL busy_len: got %0d/%0d expected 8/6", cnt8, cnt6);
        end
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 3'd0, 8'h00, 3'(k), 3'(k), 1'b0, 1'b0);
            #1;
            n_checks++;
            if (o_a[0] !== 8'h00) begin
                n_errors++;
                $display("FAIL cleared addr=%0d: got %h expected 00", k, o_a[0]);
            end
            cycle();
        end
    endtask

    task automatic test_reject();
        int cnt8, rej_cnt, rej_at;
        cnt8 = 0;
        rej_cnt = 0;
        rej_at = 0;
        fill(8'h20);
        drive(1'b0, 3'd0, 8'h00, 3'd2, 3'd0, 1'b1, 1'b0);
        cycle();
        for (int j = 1; j <= 12; j++) begin
            drive(1'b0, 3'd0, 8'h00, 3'd2, 3'd1, 1'b0, 1'b0);
            #1;
            if (o_busy[0]) cnt8++;
            if (o_rej[0]) begin
                rej_cnt++;
                rej_at = cnt8;
            end
            if (o_busy[0] && cnt8 == 3) drive(1'b1, 3'd2, 8'hFF, 3'd2, 3'd1, 1'b0, 1'b0);
            if (o_busy[0] && cnt8 == 5) drive(1'b0, 3'd0, 8'h00, 3'd2, 3'd1, 1'b1, 1'b0);
            cycle();
        end
        n_checks++;
        if (cnt8 != 8) begin
            n_errors++;
            $display("FAIL reclr_busy_len: got %0d expected 8", cnt8);
        end
        n_checks++;
        if (rej_cnt != 1 || rej_at != 4) begin
            n_errors++;
            $display("FAIL wr_rej_pulse: got count=%0d at=%0d expected count=1 at=4", rej_cnt, rej_at);
        end
        drive(1'b0, 3'd0, 8'h00, 3'd2, 3'd2, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (o_a[0] !== 8'h00) begin
            n_errors++;
            $display("FAIL rejected_write: got %h expected 00", o_a[0]);
        end
        cycle();
    endtask

    task automatic test_out_of_range();
        drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b1);
        cycle();
        drive(1'b1, 3'd6, 8'h55, 3'd6, 3'd7, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (o_a[1] !== 8'h00 || o_b[1] !== 8'h00) begin
            n_errors++;
            $display("FAIL oor_no_bypass: got %h/%h expected 00/00", o_a[1], o_b[1]);
        end
        cycle();
        n_checks++;
        if (o_rej[1] !== 1'b0) begin
            n_errors++;
            $display("FAIL oor_wr_rej: got %b expected 0", o_rej[1]);
        end
        drive(1'b0, 3'd0, 8'h00, 3'd6, 3'd7, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (o_a[1] !== 8'h00 || o_b[1] !== 8'h00 || o_a[0] !== 8'h55) begin
            n_errors++;
            $display("FAIL oor_read: got d6=%h/%h d8=%h expected 00/00 55", o_a[1], o_b[1], o_a[0]);
        end
        cycle();
        // reset on the 2nd clear cycle aborts the clear
        drive(1'b0, 3'd0, 8'h00, 3'd6, 3'd0, 1'b1, 1'b0);
        cycle();
        drive(1'b0, 3'd0, 8'h00, 3'd6, 3'd0, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 3'd0, 8'h00, 3'd6, 3'd0, 1'b0, 1'b1);
        cycle();
        n_checks++;
        if (o_busy[0] !== 1'b0 || o_busy[1] !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_abort_busy: got %b/%b expected 0/0", o_busy[0], o_busy[1]);
        end
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 3'd0, 8'h00, 3'(k), 3'(k), 1'b0, 1'b0);
            #1;
            n_checks++;
            if (o_a[0] !== 8'h00 || o_a[1] !== 8'h00) begin
                n_errors++;
                $display("FAIL reset_abort_zero addr=%0d: got %h/%h expected 00", k, o_a[0], o_a[1]);
            end
            cycle();
        end
    endtask

`ifdef REGFILE_PARITY_EN
    task automatic test_parity();
        drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b1);
        cycle();
        drive(1'b1, 3'd4, 8'h01, 3'd4, 3'd3, 1'b0, 1'b0);
        par_inj = 1'b1;
        cycle();
        drive(1'b0, 3'd0, 8'h00, 3'd4, 3'd3, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (o_pa[0] !== 1'b1 || o_pb[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL parity_inject: got a=%b b=%b expected 1 0", o_pa[0], o_pb[0]);
        end
        cycle();
        drive(1'b1, 3'd4, 8'h01, 3'd0, 3'd1, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 3'd0, 8'h00, 3'd4, 3'd5, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (o_pa[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL parity_rewrite: got %b expected 0", o_pa[0]);
        end
        cycle();
    endtask
`endif

    task automatic test_random();
        drive(1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b1);
        cycle();
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0));
            par_inj = ($urandom_range(0, 3) == 0);
            cycle();
        end
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        m_depth[0] = 8;
        m_depth[1] = 6;
        test_reset();
        test_write_read();
        test_bypass();
        test_clear();
        test_reject();
        test_out_of_range();
`ifdef REGFILE_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
